// File: rtl/nanorv32_irq_ctrl_if.sv
// nanorv32_irq_ctrl_if: signal bundle between the core flow-control stage
// (master) and the interrupt controller (slave). clk/rst are not part of it.
interface nanorv32_irq_ctrl_if #(
  parameter int NUM_IRQ  = 8,
  parameter int IRQ_ID_W = 3
) ();
  logic [NUM_IRQ-1:0]  irq_src;
  logic                mask_wr;
  logic [NUM_IRQ-1:0]  mask_wdata;
  logic [NUM_IRQ-1:0]  pend_clr;
  logic                irq_ack;
  logic                interrupt_state_r;
  logic                reti_inst_detected;
  logic                irq;
  logic [IRQ_ID_W-1:0] irq_id;
  logic                irq_active;
  logic [NUM_IRQ-1:0]  mask_r;
  logic [NUM_IRQ-1:0]  pending_r;

  // Core / system side: drives sources, mask writes and the handshake.
  modport master (
    output irq_src, mask_wr, mask_wdata, pend_clr,
           irq_ack, interrupt_state_r, reti_inst_detected,
    input  irq, irq_id, irq_active, mask_r, pending_r
  );

  // Controller side.
  modport slave (
    input  irq_src, mask_wr, mask_wdata, pend_clr,
           irq_ack, interrupt_state_r, reti_inst_detected,
    output irq, irq_id, irq_active, mask_r, pending_r
  );
endinterface

// File: rtl/nanorv32_irq_ctrl.sv
// nanorv32_irq_ctrl: pending/mask registers plus a three-state request FSM
// (IDLE -> REQ -> SERVICE) feeding the nanorv32 flow-control stage.
// Lowest enabled pending index wins; no nesting while in SERVICE.
// Optional feature: define NANORV32_IRQ_CTRL_EDGE_EN to pend on rising edges of
// irq_src instead of on its level.
module nanorv32_irq_ctrl #(
  parameter int NUM_IRQ  = 8,
  parameter int IRQ_ID_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  nanorv32_irq_ctrl_if.slave       irq_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_irq;
  logic                r_irq_active;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [NUM_IRQ-1:0]  r_pending;

  logic [NUM_IRQ-1:0]  w_set;
  logic [NUM_IRQ-1:0]  w_id_hit;
  logic [NUM_IRQ-1:0]  w_ack_clr;
  logic [NUM_IRQ-1:0]  w_pending_next;
  logic [NUM_IRQ-1:0]  w_mask_next;
  logic [NUM_IRQ-1:0]  w_enabled;
  logic [IRQ_ID_W-1:0] w_lowest_id;
  logic                w_any;
  logic                w_ack_in_req;
  logic                w_sel_keep;
  logic                w_reti;

`ifdef NANORV32_IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0]  r_irq_src_d;

  // Edge history: previous-cycle copy of the source lines.
  always_ff @(posedge clk) begin
    if (rst) r_irq_src_d <= '0;
    else     r_irq_src_d <= irq_bus.irq_src;
  end

  assign w_set = irq_bus.irq_src & ~r_irq_src_d;
`else
  assign w_set = irq_bus.irq_src;
`endif

  assign w_ack_in_req = (r_state == ST_REQ) && irq_bus.irq_ack;
  assign w_reti       = irq_bus.reti_inst_detected && irq_bus.interrupt_state_r;

  // One-hot decode of the latched id, so no variable part-select is needed
  // when NUM_IRQ is smaller than 2**IRQ_ID_W.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_id_hit
      assign w_id_hit[gi] = (r_irq_id == IRQ_ID_W'(gi));
    end
  endgenerate

  assign w_ack_clr      = w_id_hit & {NUM_IRQ{w_ack_in_req}};
  // A set arriving in the same cycle as any clear keeps the bit pending.
  assign w_pending_next = w_set | (r_pending & ~irq_bus.pend_clr & ~w_ack_clr);
  assign w_mask_next    = irq_bus.mask_wr ? irq_bus.mask_wdata : r_mask;
  assign w_enabled      = r_pending & r_mask;
  assign w_any          = |w_enabled;
  // Request stays valid only if the selected bit is still pending and enabled
  // after this cycle's clears and mask write; otherwise it is withdrawn.
  assign w_sel_keep     = |(w_id_hit & w_pending_next & w_mask_next);

  // Lowest-index priority encoder over enabled pending bits.
  always_comb begin
    w_lowest_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_enabled[i]) w_lowest_id = IRQ_ID_W'(i);
    end
  end

  // Mask and pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask    <= '0;
      r_pending <= '0;
    end else begin
      r_mask    <= w_mask_next;
      r_pending <= w_pending_next;
    end
  end

  // Request FSM with registered irq / irq_active / irq_id.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_irq        <= 1'b0;
      r_irq_active <= 1'b0;
      r_irq_id     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_REQ;
            r_irq_id <= w_lowest_id;
            r_irq    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (irq_bus.irq_ack) begin
            r_state      <= ST_SERVICE;
            r_irq        <= 1'b0;
            r_irq_active <= 1'b1;
          end else if (!w_sel_keep) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (w_reti) begin
            r_state      <= ST_IDLE;
            r_irq_active <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_irq        <= 1'b0;
          r_irq_active <= 1'b0;
        end
      endcase
    end
  end

  assign irq_bus.irq        = r_irq;
  assign irq_bus.irq_active = r_irq_active;
  assign irq_bus.irq_id     = r_irq_id;
  assign irq_bus.mask_r     = r_mask;
  assign irq_bus.pending_r  = r_pending;

endmodule

// File: doc/nanorv32_irq_ctrl.md
NANORV32_IRQ_CTRL -- requirements
Module: nanorv32_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8: number of interrupt source lines (2..32).
REQ-002 Parameter IRQ_ID_W, default 3: width of the source index; SHALL satisfy 2**IRQ_ID_W >= NUM_IRQ.
REQ-003 clk  input  1  single core clock; all flops on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 irq_src  input  NUM_IRQ  external interrupt lines, synchronous to clk.
REQ-006 mask_wr  input  1  one-cycle strobe; loads mask_wdata into mask_r.
REQ-007 mask_wdata  input  NUM_IRQ  new enable mask (1 = enabled).
REQ-008 pend_clr  input  NUM_IRQ  one-cycle software clear of pending bits.
REQ-009 irq_ack  input  1  core accepts the interrupt (flow-control entry sequence started).
REQ-010 interrupt_state_r  input  1  core is executing inside an interrupt context.
REQ-011 reti_inst_detected  input  1  return-from-interrupt instruction in decode.
REQ-012 irq  output  1  interrupt request to the flow-control stage.
REQ-013 irq_id  output  IRQ_ID_W  index of the requested or in-service source.
REQ-014 irq_active  output  1  a source is in service.
REQ-015 mask_r  output  NUM_IRQ  current enable mask.
REQ-016 pending_r  output  NUM_IRQ  current pending bits.

Function
REQ-017 FSM states: IDLE, REQ, SERVICE; registered state.
REQ-018 Pending set event per bit i: a new event on irq_src[i], as defined under Configuration.
REQ-019 pending_r[i] next = set_i | (pending_r[i] & ~pend_clr[i] & ~ack_clr_i); a same-cycle set wins over any clear.
REQ-020 ack_clr_i is 1 only when state = REQ, irq_ack = 1 and irq_id = i.
REQ-021 IDLE: if (pending_r & mask_r) != 0, latch the lowest set index into irq_id and go to REQ next cycle; otherwise stay in IDLE.
REQ-022 REQ: irq = 1; on irq_ack go to SERVICE and clear pending_r[irq_id]; otherwise stay in REQ with irq_id stable.
REQ-023 REQ with the selected bit masked off or cleared before irq_ack: return to IDLE next cycle, irq deasserted that cycle (request withdrawn).
REQ-024 SERVICE: irq = 0, irq_active = 1; on reti_inst_detected & interrupt_state_r go to IDLE next cycle.
REQ-025 No nesting: new pending bits accumulate during SERVICE but are not requested until IDLE.
REQ-026 Latency: a pending bit set in cycle N (IDLE, enabled) gives irq = 1 in cycle N+2; back-to-back sources give irq = 1 two cycles after the return to IDLE.
REQ-027 irq and irq_active are decoded from the registered state only (no combinational path from inputs).
REQ-028 mask_wr takes effect the next cycle; mask_r does not alter pending_r.
REQ-029 irq_ack outside REQ is ignored; reti_inst_detected outside SERVICE is ignored.

Reset
REQ-030 On rst: state = IDLE, irq = 0, irq_active = 0, irq_id = 0, pending_r = 0, mask_r = 0, edge history = 0.
REQ-031 rst asserted mid-REQ or mid-SERVICE aborts at once; the first cycle after rst deassertion is IDLE with all outputs at reset values.

Configuration
REQ-032 Macro NANORV32_IRQ_CTRL_EDGE_EN.
REQ-033 Macro defined: irq_src is registered each cycle; set_i = irq_src[i] & ~irq_src_d[i] (rising edge). A line held high sets pending once.
REQ-034 Macro undefined: set_i = irq_src[i] (level); the edge register is not instantiated, and a held line re-pends immediately after the ack clears it.

Verification
REQ-035 Reset sequence: rst high 2 cycles, irq_src = 0xFF -> pending_r = 0, irq = 0, mask_r = 0 during reset and on the first cycle after deassertion.
REQ-036 Edge build: mask = 0xFF, pulse irq_src[5] for one cycle at cycle N -> pending_r[5] = 1 at N+1, irq = 1 with irq_id = 5 at N+2; irq_ack -> pending_r = 0 and irq_active = 1 next cycle.
REQ-037 Priority: pending bits 2, 6 and 7 set together, mask = 0xFF -> irq_id = 2; after ack and reti, irq_id = 6, then 7.
REQ-038 Simultaneous events: a new edge on bit 3 in the same cycle as irq_ack for irq_id = 3 -> pending_r[3] = 1 after that cycle.
REQ-039 Withdrawal: in REQ for bit 4, write mask = 0xEF before irq_ack -> state IDLE and irq = 0 next cycle, pending_r[4] still 1.
REQ-040 Level build, macro undefined: irq_src[1] held high, ack then reti -> irq reasserts with irq_id = 1 two cycles after the return to IDLE.
